// File: rtl/prach_hdr_pkg.sv
// prach_hdr_pkg: shared PRACH U-plane header types, constants and helpers
package prach_hdr_pkg;
  localparam int SC_PER_PRB = 12;
  localparam int BYTES_PER_SC = 4;
  localparam int MAX_SYM = 14;
  localparam logic UL_DIR = 1'b0;
  localparam logic [2:0] PAYLOAD_VER = 3'd1;
  localparam logic [7:0] UDCOMP_NONE = 8'h00;
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
  typedef struct packed {
    logic [15:0] pc_id;
    logic [3:0] filt;
    logic [7:0] frame;
    logic [3:0] subframe;
    logic [5:0] slot;
    logic [5:0] start_sym;
    logic [11:0] section;
    logic [9:0] start_prb;
    logic [7:0] num_prb;
  } cfg_t;
  typedef struct packed {
    logic [15:0] pc_id;
    logic dir;
    logic [2:0] ver;
    logic [3:0] filt;
    logic [7:0] frame;
    logic [3:0] subframe;
    logic [5:0] slot;
    logic [5:0] sym;
    logic [11:0] section;
    logic rb;
    logic sym_inc;
    logic [9:0] start_prb;
    logic [7:0] num_prb;
    logic [7:0] comp;
    logic [15:0] size;
    logic [15:0] rsvd;
  } hdr_t;
  function automatic logic cfg_legal(input logic [7:0] num_prb, input logic [3:0] num_sym);
    return num_prb != 8'd0 && num_sym != 4'd0 && num_sym <= 4'(MAX_SYM);
  endfunction
  function automatic logic [11:0] pkt_samples(input logic [7:0] num_prb);
    return 12'(num_prb) * 12'(SC_PER_PRB);
  endfunction
endpackage

// File: rtl/prach_hdr_if.sv
// prach_hdr_if: sample stream, timing/config and header bundle between source and generator
interface prach_hdr_if;
  logic [15:0] din_dr;
  logic [15:0] din_di;
  logic din_dv;
  logic occ_start;
  logic [7:0] tm_frame;
  logic [3:0] tm_subframe;
  logic [5:0] tm_slot;
  logic [15:0] cfg_pc_id;
  logic [3:0] cfg_filter_idx;
  logic [5:0] cfg_start_sym;
  logic [3:0] cfg_num_sym;
  logic [11:0] cfg_section_id;
  logic [9:0] cfg_start_prb;
  logic [7:0] cfg_num_prb;
  logic [15:0] dout_dr;
  logic [15:0] dout_di;
  logic dout_dv;
  logic sync_out;
  logic [119:0] hdr_out;
  logic busy;
  logic err_overlap;
  logic err_cfg;
  modport master (
    output din_dr, din_di, din_dv, occ_start, tm_frame, tm_subframe, tm_slot,
           cfg_pc_id, cfg_filter_idx, cfg_start_sym, cfg_num_sym, cfg_section_id,
           cfg_start_prb, cfg_num_prb,
    input  dout_dr, dout_di, dout_dv, sync_out, hdr_out, busy, err_overlap, err_cfg
  );
  modport slave (
    input  din_dr, din_di, din_dv, occ_start, tm_frame, tm_subframe, tm_slot,
           cfg_pc_id, cfg_filter_idx, cfg_start_sym, cfg_num_sym, cfg_section_id,
           cfg_start_prb, cfg_num_prb,
    output dout_dr, dout_di, dout_dv, sync_out, hdr_out, busy, err_overlap, err_cfg
  );
endinterface

// File: rtl/prach_hdr_pack.sv
// prach_hdr_pack: packs latched occasion fields and current symbol index into the header word
module prach_hdr_pack
  import prach_hdr_pkg::*;
(
  input  cfg_t cfg,
  input  logic [3:0] sym_cnt,
  output hdr_t hdr
);
  assign hdr = '{
    pc_id: cfg.pc_id,
    dir: UL_DIR,
    ver: PAYLOAD_VER,
    filt: cfg.filt,
    frame: cfg.frame,
    subframe: cfg.subframe,
    slot: cfg.slot,
    sym: cfg.start_sym + 6'(sym_cnt),
    section: cfg.section,
    rb: 1'b0,
    sym_inc: 1'b0,
    start_prb: cfg.start_prb,
    num_prb: cfg.num_prb,
    comp: UDCOMP_NONE,
    size: 16'(cfg.num_prb) * 16'(SC_PER_PRB * BYTES_PER_SC),
    rsvd: 16'h0000
  };
endmodule

// File: rtl/prach_hdr_gen.sv
// prach_hdr_gen: forwards PRACH samples with 1-cycle latency, slices them into packets and emits headers
module prach_hdr_gen
  import prach_hdr_pkg::*;
(
  input logic clk_dsp,
  input logic rst_dsp_n,
  prach_hdr_if.slave bus
);
  state_t state;
  cfg_t cfg_q;
  cfg_t cfg_in;
  hdr_t hdr_n;
  logic [3:0] num_sym_q;
  logic [3:0] sym_cnt;
  logic [11:0] pkt_len;
  logic [11:0] samp_cnt;
  logic legal;
  logic last;
  assign cfg_in = '{
    pc_id: bus.cfg_pc_id,
    filt: bus.cfg_filter_idx,
    frame: bus.tm_frame,
    subframe: bus.tm_subframe,
    slot: bus.tm_slot,
    start_sym: bus.cfg_start_sym,
    section: bus.cfg_section_id,
    start_prb: bus.cfg_start_prb,
    num_prb: bus.cfg_num_prb
  };
  assign legal = cfg_legal(bus.cfg_num_prb, bus.cfg_num_sym);
  assign last = samp_cnt == pkt_len - 12'd1;
  assign bus.busy = state != IDLE;
  prach_hdr_pack u_pack (
    .cfg(cfg_q),
    .sym_cnt(sym_cnt),
    .hdr(hdr_n)
  );
  // Occasion FSM: sample forwarding and packet slicing first, then occ_start overrides the state
  always_ff @(posedge clk_dsp) begin
    if (!rst_dsp_n) begin
      state <= IDLE;
      cfg_q <= '0;
      num_sym_q <= '0;
      sym_cnt <= '0;
      pkt_len <= '0;
      samp_cnt <= '0;
      bus.dout_dr <= '0;
      bus.dout_di <= '0;
      bus.dout_dv <= 1'b0;
      bus.sync_out <= 1'b0;
      bus.hdr_out <= '0;
      bus.err_overlap <= 1'b0;
      bus.err_cfg <= 1'b0;
    end else begin
      bus.dout_dv <= 1'b0;
      bus.sync_out <= 1'b0;
      if (state != IDLE && bus.din_dv) begin
        bus.dout_dr <= bus.din_dr;
        bus.dout_di <= bus.din_di;
        bus.dout_dv <= 1'b1;
        bus.sync_out <= samp_cnt == 12'd0;
        if (samp_cnt == 12'd0) bus.hdr_out <= hdr_n;
        samp_cnt <= last ? 12'd0 : samp_cnt + 12'd1;
        state <= RUN;
        if (last) begin
          sym_cnt <= sym_cnt + 4'd1;
          if (sym_cnt + 4'd1 == num_sym_q) state <= IDLE;
        end
      end
      if (bus.occ_start) begin
        if (state != IDLE) bus.err_overlap <= 1'b1;
        if (legal) begin
          cfg_q <= cfg_in;
          num_sym_q <= bus.cfg_num_sym;
          pkt_len <= pkt_samples(bus.cfg_num_prb);
          samp_cnt <= 12'd0;
          sym_cnt <= 4'd0;
          state <= ARMED;
        end else begin
          bus.err_cfg <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_prach_hdr_gen.sv
// tb_prach_hdr_gen: directed self-checking bench for the PRACH header generator
module tb_prach_hdr_gen;
  logic clk_dsp = 1'b0;
  logic rst_dsp_n = 1'b0;
  int pass_cnt = 0;
  int total = 0;
  always #5 clk_dsp = ~clk_dsp;
  prach_hdr_if bus();
  prach_hdr_gen dut (
    .clk_dsp(clk_dsp),
    .rst_dsp_n(rst_dsp_n),
    .bus(bus)
  );
  function automatic logic [119:0] exp_hdr(input logic [7:0] frame, input logic [5:0] sym, input logic [7:0] prb);
    return {16'hA5C3, 1'b0, 3'd1, 4'd2, frame, 4'd3, 6'd5, sym, 12'h123, 2'b00, 10'd7, prb, 8'h00, 16'(prb * 48), 16'h0000};
  endfunction
  task automatic set_cfg(input logic [7:0] prb, input logic [3:0] nsym, input logic [5:0] ssym, input logic [7:0] frame);
    bus.cfg_num_prb = prb;
    bus.cfg_num_sym = nsym;
    bus.cfg_start_sym = ssym;
    bus.tm_frame = frame;
    bus.tm_subframe = 4'd3;
    bus.tm_slot = 6'd5;
    bus.cfg_pc_id = 16'hA5C3;
    bus.cfg_filter_idx = 4'd2;
    bus.cfg_section_id = 12'h123;
    bus.cfg_start_prb = 10'd7;
  endtask
  task automatic occ;
    bus.occ_start = 1'b1;
    @(negedge clk_dsp);
    bus.occ_start = 1'b0;
  endtask
  task automatic stream(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bus.din_dv = 1'b1;
      bus.din_dr = 16'(base + i);
      bus.din_di = ~16'(base + i);
      @(negedge clk_dsp);
    end
    bus.din_dv = 1'b0;
  endtask
  task automatic do_reset;
    rst_dsp_n = 1'b0;
    bus.din_dv = 1'b0;
    bus.occ_start = 1'b0;
    @(negedge clk_dsp);
    rst_dsp_n = 1'b1;
  endtask
  task automatic test_reset;
    bus.din_dv = 1'b1;
    bus.din_dr = 16'h1234;
    bus.din_di = 16'h5678;
    bus.occ_start = 1'b0;
    set_cfg(8'd4, 4'd1, 6'd0, 8'h01);
    @(negedge clk_dsp);
    @(negedge clk_dsp);
    total++; if (bus.dout_dv !== 1'b0) $display("FAIL reset_dv got %b want 0", bus.dout_dv); else pass_cnt++;
    total++; if (bus.dout_dr !== 16'h0 || bus.dout_di !== 16'h0) $display("FAIL reset_data got %h/%h want 0", bus.dout_dr, bus.dout_di); else pass_cnt++;
    total++; if (bus.hdr_out !== 120'h0) $display("FAIL reset_hdr got %h want 0", bus.hdr_out); else pass_cnt++;
    total++; if ({bus.sync_out, bus.busy, bus.err_overlap, bus.err_cfg} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {bus.sync_out, bus.busy, bus.err_overlap, bus.err_cfg}); else pass_cnt++;
    rst_dsp_n = 1'b1;
    @(negedge clk_dsp);
    total++; if (bus.dout_dv !== 1'b0) $display("FAIL idle_drop got %b want 0", bus.dout_dv); else pass_cnt++;
    bus.din_dv = 1'b0;
  endtask
  task automatic test_nominal;
    set_cfg(8'd70, 4'd2, 6'd0, 8'h11);
    occ;
    total++; if (bus.busy !== 1'b1) $display("FAIL nom_armed_busy got %b want 1", bus.busy); else pass_cnt++;
    for (int i = 0; i < 1680; i++) begin
      bus.din_dv = 1'b1;
      bus.din_dr = 16'(i);
      bus.din_di = ~16'(i);
      @(negedge clk_dsp);
      total++; if (bus.dout_dv !== 1'b1 || bus.dout_dr !== 16'(i) || bus.dout_di !== ~16'(i)) $display("FAIL nom_data i=%0d got %b %h %h want 1 %h", i, bus.dout_dv, bus.dout_dr, bus.dout_di, 16'(i)); else pass_cnt++;
      total++; if (bus.sync_out !== (i == 0 || i == 840)) $display("FAIL nom_sync i=%0d got %b", i, bus.sync_out); else pass_cnt++;
      if (i == 0 || i == 840) begin
        total++; if (bus.hdr_out !== exp_hdr(8'h11, (i == 0) ? 6'd0 : 6'd1, 8'd70)) $display("FAIL nom_hdr i=%0d got %h want %h", i, bus.hdr_out, exp_hdr(8'h11, (i == 0) ? 6'd0 : 6'd1, 8'd70)); else pass_cnt++;
      end
      if (i == 1678 || i == 1679) begin
        total++; if (bus.busy !== (i == 1678)) $display("FAIL nom_busy i=%0d got %b", i, bus.busy); else pass_cnt++;
      end
    end
    total++; if (bus.hdr_out[31:16] !== 16'd3360) $display("FAIL nom_size got %0d want 3360", bus.hdr_out[31:16]); else pass_cnt++;
    bus.din_dv = 1'b0;
    @(negedge clk_dsp);
    total++; if (bus.dout_dv !== 1'b0 || bus.dout_dr !== 16'd1679) $display("FAIL nom_hold got %b %h want 0 %h", bus.dout_dv, bus.dout_dr, 16'd1679); else pass_cnt++;
    stream(3, 5000);
    @(negedge clk_dsp);
    total++; if (bus.dout_dv !== 1'b0 || bus.dout_dr !== 16'd1679) $display("FAIL nom_after_drop got %b %h want 0 %h", bus.dout_dv, bus.dout_dr, 16'd1679); else pass_cnt++;
  endtask
  task automatic test_bursty;
    int k;
    k = 0;
    set_cfg(8'd1, 4'd1, 6'd4, 8'h22);
    occ;
    for (int c = 0; c < 39; c++) begin
      bus.din_dv = (c % 3 == 0);
      bus.din_dr = 16'(c + 100);
      bus.din_di = 16'(c);
      @(negedge clk_dsp);
      total++; if (bus.dout_dv !== (c % 3 == 0 && k < 12)) $display("FAIL burst_dv c=%0d got %b", c, bus.dout_dv); else pass_cnt++;
      total++; if (bus.sync_out !== (c == 0)) $display("FAIL burst_sync c=%0d got %b", c, bus.sync_out); else pass_cnt++;
      if (c % 3 == 0 && k < 12) begin
        total++; if (bus.dout_dr !== 16'(c + 100)) $display("FAIL burst_data c=%0d got %h want %h", c, bus.dout_dr, 16'(c + 100)); else pass_cnt++;
        k++;
      end
      if (c == 0) begin
        total++; if (bus.hdr_out !== exp_hdr(8'h22, 6'd4, 8'd1)) $display("FAIL burst_hdr got %h want %h", bus.hdr_out, exp_hdr(8'h22, 6'd4, 8'd1)); else pass_cnt++;
      end
      if (c == 32 || c == 33) begin
        total++; if (bus.busy !== (c == 32)) $display("FAIL burst_busy c=%0d got %b", c, bus.busy); else pass_cnt++;
      end
    end
    bus.din_dv = 1'b0;
  endtask
  task automatic test_illegal;
    set_cfg(8'd0, 4'd2, 6'd0, 8'h01);
    occ;
    stream(2, 0);
    total++; if (bus.err_cfg !== 1'b1 || bus.busy !== 1'b0 || bus.dout_dv !== 1'b0) $display("FAIL ill_prb got err=%b busy=%b dv=%b want 1 0 0", bus.err_cfg, bus.busy, bus.dout_dv); else pass_cnt++;
    do_reset;
    total++; if (bus.err_cfg !== 1'b0) $display("FAIL ill_clear got %b want 0", bus.err_cfg); else pass_cnt++;
    set_cfg(8'd5, 4'd15, 6'd0, 8'h01);
    occ;
    stream(2, 0);
    total++; if (bus.err_cfg !== 1'b1 || bus.busy !== 1'b0 || bus.dout_dv !== 1'b0) $display("FAIL ill_sym got err=%b busy=%b dv=%b want 1 0 0", bus.err_cfg, bus.busy, bus.dout_dv); else pass_cnt++;
    total++; if (bus.err_overlap !== 1'b0) $display("FAIL ill_no_overlap got %b want 0", bus.err_overlap); else pass_cnt++;
    do_reset;
  endtask
  task automatic test_overlap;
    set_cfg(8'd70, 4'd2, 6'd0, 8'h33);
    occ;
    stream(500, 0);
    set_cfg(8'd70, 4'd2, 6'd9, 8'h44);
    bus.occ_start = 1'b1;
    bus.din_dv = 1'b1;
    bus.din_dr = 16'd500;
    @(negedge clk_dsp);
    bus.occ_start = 1'b0;
    bus.din_dv = 1'b0;
    total++; if (bus.dout_dv !== 1'b1 || bus.dout_dr !== 16'd500 || bus.sync_out !== 1'b0) $display("FAIL ovl_old got %b %h %b want 1 01f4 0", bus.dout_dv, bus.dout_dr, bus.sync_out); else pass_cnt++;
    total++; if (bus.err_overlap !== 1'b1 || bus.busy !== 1'b1) $display("FAIL ovl_flag got err=%b busy=%b want 1 1", bus.err_overlap, bus.busy); else pass_cnt++;
    @(negedge clk_dsp);
    total++; if (bus.dout_dv !== 1'b0) $display("FAIL ovl_gap got %b want 0", bus.dout_dv); else pass_cnt++;
    stream(1, 16'h0BEE);
    total++; if (bus.sync_out !== 1'b1 || bus.dout_dr !== 16'h0BEE) $display("FAIL ovl_sync got %b %h want 1 0bee", bus.sync_out, bus.dout_dr); else pass_cnt++;
    total++; if (bus.hdr_out !== exp_hdr(8'h44, 6'd9, 8'd70)) $display("FAIL ovl_hdr got %h want %h", bus.hdr_out, exp_hdr(8'h44, 6'd9, 8'd70)); else pass_cnt++;
    do_reset;
  endtask
  task automatic test_wrap;
    set_cfg(8'd1, 4'd2, 6'd63, 8'h55);
    occ;
    for (int i = 0; i < 24; i++) begin
      stream(1, i);
      if (i == 0 || i == 12) begin
        total++; if (bus.sync_out !== 1'b1 || bus.hdr_out[77:72] !== ((i == 0) ? 6'd63 : 6'd0)) $display("FAIL wrap_sym i=%0d got sync=%b sym=%0d", i, bus.sync_out, bus.hdr_out[77:72]); else pass_cnt++;
      end
    end
    total++; if (bus.busy !== 1'b0) $display("FAIL wrap_done got %b want 0", bus.busy); else pass_cnt++;
  endtask
  task automatic test_reset_mid;
    set_cfg(8'd70, 4'd2, 6'd0, 8'h66);
    occ;
    stream(300, 0);
    rst_dsp_n = 1'b0;
    bus.din_dv = 1'b1;
    bus.din_dr = 16'd300;
    @(negedge clk_dsp);
    total++; if ({bus.dout_dv, bus.sync_out, bus.busy, bus.err_overlap, bus.err_cfg} !== 5'b0 || bus.dout_dr !== 16'h0 || bus.hdr_out !== 120'h0) $display("FAIL rst_mid got dv=%b busy=%b dr=%h hdr=%h want all 0", bus.dout_dv, bus.busy, bus.dout_dr, bus.hdr_out); else pass_cnt++;
    rst_dsp_n = 1'b1;
    stream(4, 301);
    total++; if (bus.dout_dv !== 1'b0 || bus.busy !== 1'b0 || bus.dout_dr !== 16'h0) $display("FAIL rst_mid_drop got dv=%b busy=%b dr=%h want 0 0 0", bus.dout_dv, bus.busy, bus.dout_dr); else pass_cnt++;
  endtask
  initial begin
    bus.din_dv = 1'b0;
    bus.din_dr = '0;
    bus.din_di = '0;
    bus.occ_start = 1'b0;
    set_cfg(8'd0, 4'd0, 6'd0, 8'h00);
    @(negedge clk_dsp);
    test_reset;
    test_nominal;
    test_bursty;
    test_illegal;
    test_overlap;
    test_wrap;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
